// File: rtl/iterative_alu.sv
// Iterative ALU: single-cycle arithmetic/logic ops, plus a bit-serial barrel-free
// shifter and a shift-add multiplier that each retire one bit per clock.
module iterative_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             carry,
    output logic             low,
    output logic             flag,
    output logic             zero,
    output logic             negative
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SHIFT_RUN = 2'd1;
    localparam logic [1:0] S_MUL_RUN   = 2'd2;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_CMP   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_XOR   = 3'b101;
    localparam logic [2:0] OP_SHIFT = 3'b110;
    localparam logic [2:0] OP_MUL   = 3'b111;

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    C_ONE = CW'(1);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_sh;
    logic               r_left;
    logic               r_over;
    logic               r_done;
    logic [WIDTH-1:0]   r_d;
    logic               r_carry, r_low, r_flag, r_zero, r_negative;

    logic [WIDTH:0]     w_sum, w_diff;
    logic [WIDTH-1:0]   w_mag;
    logic               w_over;
    logic [CW-1:0]      w_n;
    logic [WIDTH-1:0]   w_res;
    logic               w_c, w_l, w_f, w_neg;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [WIDTH-1:0]   w_sh_next;
    logic               w_last_next;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    // Shift amount is |signed b| clamped to WIDTH; beyond WIDTH the carry reads as 0.
    assign w_mag  = b[WIDTH-1] ? (~b + ONE) : b;
    assign w_over = (w_mag > W_VAL);
    assign w_n    = w_over ? CW'(WIDTH) : CW'(w_mag);

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_l   = 1'b0;
        w_f   = 1'b0;
        w_neg = 1'b0;
        case (operation)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_f   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_f   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_CMP: begin
                w_res = w_diff[WIDTH-1:0];
                w_l   = w_diff[WIDTH];
                w_neg = ($signed(a) < $signed(b));
            end
            OP_AND: begin
                w_res = a & b;
                w_neg = a[WIDTH-1] & b[WIDTH-1];
            end
            OP_OR: begin
                w_res = a | b;
                w_neg = a[WIDTH-1] | b[WIDTH-1];
            end
            OP_XOR: begin
                w_res = a ^ b;
                w_neg = a[WIDTH-1] ^ b[WIDTH-1];
            end
            OP_SHIFT: w_res = a;
            default:  w_res = '0;
        endcase
    end

    // Shift-add step: conditionally add the multiplicand into the high half, then shift right.
    assign w_add       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
    assign w_prod_next = {w_add, r_prod[WIDTH-1:1]};

    assign w_sh_next   = r_left ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};
    assign w_last_next = r_left ? r_sh[WIDTH-1] : r_sh[0];

    // NOTE: working registers (r_a, r_prod, r_sh, r_cnt, ...) are loaded on accept and
    // never read before that, so only the state and the visible outputs are reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b0;
            r_d        <= '0;
            r_carry    <= 1'b0;
            r_low      <= 1'b0;
            r_flag     <= 1'b0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (operation == OP_MUL) begin
                            r_a     <= a;
                            r_prod  <= {{WIDTH{1'b0}}, b};
                            r_cnt   <= CW'(WIDTH);
                            r_state <= S_MUL_RUN;
                        end else if (operation == OP_SHIFT && w_n != '0) begin
                            r_sh    <= a;
                            r_left  <= ~b[WIDTH-1];
                            r_over  <= w_over;
                            r_cnt   <= w_n;
                            r_state <= S_SHIFT_RUN;
                        end else begin
                            r_d        <= w_res;
                            r_carry    <= w_c;
                            r_low      <= w_l;
                            r_flag     <= w_f;
                            r_zero     <= (w_res == '0);
                            r_negative <= w_neg;
                            r_done     <= 1'b1;
                        end
                    end
                end
                S_SHIFT_RUN: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt - C_ONE;
                    if (r_cnt == C_ONE) begin
                        r_state    <= S_IDLE;
                        r_done     <= 1'b1;
                        r_d        <= w_sh_next;
                        r_carry    <= w_last_next & ~r_over;
                        r_low      <= 1'b0;
                        r_flag     <= 1'b0;
                        r_zero     <= (w_sh_next == '0);
                        r_negative <= 1'b0;
                    end
                end
                S_MUL_RUN: begin
                    r_prod <= w_prod_next;
                    r_cnt  <= r_cnt - C_ONE;
                    if (r_cnt == C_ONE) begin
                        r_state    <= S_IDLE;
                        r_done     <= 1'b1;
                        r_d        <= w_prod_next[WIDTH-1:0];
                        r_carry    <= |w_prod_next[2*WIDTH-1:WIDTH];
                        r_low      <= 1'b0;
                        r_flag     <= 1'b0;
                        r_zero     <= (w_prod_next[WIDTH-1:0] == '0);
                        r_negative <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign d        = r_d;
    assign carry    = r_carry;
    assign low      = r_low;
    assign flag     = r_flag;
    assign zero     = r_zero;
    assign negative = r_negative;

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu: directed corner cases, randomized ops against
// an arithmetic reference model, back-to-back starts, and reset abort/priority.
module tb_iterative_alu;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   operation;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] d;
    logic         carry, low, flag, zero, negative;

    int total = 0;
    int bad   = 0;

    longint       last_d;
    logic [4:0]   last_f;

    iterative_alu #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .operation(operation),
        .a(a), .b(b), .busy(busy), .done(done), .d(d), .carry(carry),
        .low(low), .flag(flag), .zero(zero), .negative(negative)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] dut_flags();
        return {carry, low, flag, zero, negative};
    endfunction

    // Reference: result, flags {carry,low,flag,zero,negative} and done latency from plain arithmetic.
    function automatic void model(input int op, input longint av, input longint bv,
                                  output longint ed, output logic [4:0] ef, output int lat);
        longint m  = longint'(1) << W;
        longint sa = (av >= m / 2) ? av - m : av;
        longint sb = (bv >= m / 2) ? bv - m : bv;
        longint full, s, mag, n;
        bit c = 0, l = 0, f = 0, ng = 0;
        ed  = 0;
        lat = 1;
        case (op)
            0: begin
                full = av + bv; ed = full % m; c = (full >= m);
                s = sa + sb; f = (s >= m / 2) || (s < -(m / 2));
            end
            1: begin
                ed = (av - bv + m) % m; c = (av < bv);
                s = sa - sb; f = (s >= m / 2) || (s < -(m / 2));
            end
            2: begin
                ed = (av - bv + m) % m; l = (av < bv); ng = (sa < sb);
            end
            3: begin ed = av & bv; ng = (ed >= m / 2); end
            4: begin ed = av | bv; ng = (ed >= m / 2); end
            5: begin ed = av ^ bv; ng = (ed >= m / 2); end
            6: begin
                mag = (sb < 0) ? -sb : sb;
                n   = (mag > W) ? W : mag;
                lat = int'(n) + 1;
                if (n == 0) ed = av;
                else if (sb > 0) begin
                    ed = (av << n) % m;
                    c  = (mag <= W) && (((av >> (W - n)) & 1) != 0);
                end else begin
                    ed = av >> n;
                    c  = (mag <= W) && (((av >> (n - 1)) & 1) != 0);
                end
            end
            default: begin
                full = av * bv; ed = full % m; c = ((full >> W) != 0); lat = W + 1;
            end
        endcase
        ef = {c, l, f, (ed == 0), ng};
    endfunction

    // Issue one op and follow it cycle by cycle; optionally poke start while busy.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input bit poke);
        longint     ed;
        logic [4:0] ef;
        int         lat;
        model(int'(op), longint'(av), longint'(bv), ed, ef, lat);
        @(negedge clock);
        start = 1'b1; operation = op; a = av; b = bv;
        @(negedge clock);
        start = 1'b0; operation = 3'($urandom); a = W'($urandom); b = W'($urandom);
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clock);
            if (poke && k == 2) start = 1'b1;
            if (poke && k == 3) start = 1'b0;
            check("busy", 32'(busy), 32'(k < lat));
            check("done", 32'(done), 32'(k == lat));
            if (k < lat) begin
                check("hold_d", 32'(d), 32'(last_d));
                check("hold_flags", 32'(dut_flags()), 32'(last_f));
            end
        end
        check("d", 32'(d), 32'(ed));
        check("flags", 32'(dut_flags()), 32'(ef));
        last_d = ed;
        last_f = ef;
        @(negedge clock);
        check("done_once", 32'(done), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        longint     ed2;
        logic [4:0] ef2;
        int         lat2;
        logic [2:0] op;
        logic [W-1:0] bv;

        reset = 1'b1; start = 1'b0; operation = '0; a = '0; b = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_flags", 32'(dut_flags()), 32'd0);
        reset = 1'b0;
        last_d = 0;
        last_f = '0;

        run_op(3'b000, 16'h7FFF, 16'h0001, 1'b0);
        run_op(3'b001, 16'h0000, 16'h0001, 1'b0);
        run_op(3'b010, 16'hFFFF, 16'h0001, 1'b0);
        run_op(3'b110, 16'h8001, 16'hFFFF, 1'b0);
        run_op(3'b110, 16'h1234, 16'h0014, 1'b0);
        run_op(3'b111, 16'h0100, 16'h0100, 1'b0);
        run_op(3'b111, 16'h1234, 16'h5678, 1'b1);
        run_op(3'b110, 16'hA5A5, 16'h0010, 1'b0);
        run_op(3'b110, 16'hA5A5, 16'hFFF0, 1'b0);
        run_op(3'b110, 16'hA5A5, 16'h8000, 1'b0);
        run_op(3'b110, 16'hA5A5, 16'h0000, 1'b0);

        for (int i = 0; i < 250; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       bv = W'($urandom);
                1:       bv = W'($urandom_range(0, W + 2));
                default: bv = W'(-int'($urandom_range(1, W + 2)));
            endcase
            run_op(op, W'($urandom), bv, (op == 3'b111) || ($urandom_range(0, 1) == 1 && op == 3'b110 && bv > 3 && bv < 16'h8000));
        end

        // Back-to-back: start held through the done cycle is accepted at the edge ending it.
        @(negedge clock);
        start = 1'b1; operation = 3'b101; a = 16'hF0F0; b = 16'h0FF0;
        @(negedge clock);
        model(5, 64'hF0F0, 64'h0FF0, ed2, ef2, lat2);
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_d1", 32'(d), 32'(ed2));
        operation = 3'b011; a = 16'h8F00; b = 16'hF0F0;
        @(negedge clock);
        start = 1'b0;
        model(3, 64'h8F00, 64'hF0F0, ed2, ef2, lat2);
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_d2", 32'(d), 32'(ed2));
        check("b2b_flags2", 32'(dut_flags()), 32'(ef2));
        @(negedge clock);
        check("b2b_end", 32'(done), 32'd0);

        // Reset in cycle 5 of a MUL aborts it with no done pulse.
        @(negedge clock);
        start = 1'b1; operation = 3'b111; a = 16'h0003; b = 16'h0005;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("abort_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_d", 32'(d), 32'd0);
        check("abort_flags", 32'(dut_flags()), 32'd0);
        for (int k = 0; k < 20; k++) begin
            check("abort_no_done", 32'(done), 32'd0);
            @(negedge clock);
        end

        // Reset wins over start on the same edge.
        start = 1'b1; reset = 1'b1; operation = 3'b000; a = 16'h0001; b = 16'h0001;
        @(negedge clock);
        start = 1'b0; reset = 1'b0;
        check("prio_done", 32'(done), 32'd0);
        check("prio_busy", 32'(busy), 32'd0);
        check("prio_d", 32'(d), 32'd0);
        @(negedge clock);
        check("prio_done2", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
